// File: rtl/sha_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sha_stream_ctrl
// Description : Host-side initiator for one sha core. Packs a valid/ready
//               byte stream into the core's fixed-length message buffer,
//               pulses Enable, waits for Ready, captures the digest and
//               streams it back out most significant byte first.
// Revision    : 1.0 - initial release
// ============================================================================
module sha_stream_ctrl #(
    parameter int NL = 64,
    parameter int NK = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    output logic               in_ready,
    output logic [NL-1:0][7:0] sha_data,
    output logic               sha_enable,
    input  logic [NK-1:0]      sha_hash,
    input  logic               sha_ready,
    output logic               out_valid,
    output logic [7:0]         out_data,
    output logic               out_last,
    input  logic               out_ready,
    output logic               busy,
    output logic               frame_err
);

    localparam int c_NB    = NK / 8;
    localparam int c_CNT_W = (NL > 1) ? $clog2(NL) : 1;
    localparam int c_IDX_W = (c_NB > 1) ? $clog2(c_NB) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(NL - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(c_NB - 1);

    localparam logic [2:0] c_LOAD  = 3'd0;
    localparam logic [2:0] c_DRAIN = 3'd1;
    localparam logic [2:0] c_START = 3'd2;
    localparam logic [2:0] c_WAIT  = 3'd3;
    localparam logic [2:0] c_SEND  = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_IDX_W-1:0]    r_idx;
    logic [NL-1:0][7:0]    r_buf;
    logic [c_NB-1:0][7:0]  r_digest;
    logic                  r_out_valid;
    logic                  r_frame_err;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_err_set;

    // Input is only taken while collecting or discarding a frame.
    assign in_ready   = (r_state == c_LOAD) || (r_state == c_DRAIN);
    assign busy       = (r_state != c_LOAD);
    assign sha_enable = (r_state == c_START);
    assign sha_data   = r_buf;
    assign out_valid  = r_out_valid;
    assign frame_err  = r_frame_err;

    // Digest is held as bytes with the most significant byte at the top index.
    assign out_data   = r_digest[c_IDX_LAST - r_idx];
    assign out_last   = r_out_valid && (r_idx == c_IDX_LAST);

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and malformed-frame detection.
    always_comb begin
        w_next_state = r_state;
        w_err_set    = 1'b0;
        case (r_state)
            c_LOAD: begin
                if (w_in_fire) begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_next_state = in_last ? c_START : c_DRAIN;
                    end else if (in_last) begin
                        w_err_set = 1'b1;
                    end
                end
            end
            c_DRAIN: begin
                if (w_in_fire && in_last) begin
                    w_err_set    = 1'b1;
                    w_next_state = c_LOAD;
                end
            end
            c_START: w_next_state = c_WAIT;
            c_WAIT: begin
                if (sha_ready) begin
                    w_next_state = c_SEND;
                end
            end
            c_SEND: begin
                if (w_out_fire && (r_idx == c_IDX_LAST)) begin
                    w_next_state = c_LOAD;
                end
            end
            default: w_next_state = c_LOAD;
        endcase
    end

    // Datapath: message buffer, byte count, digest capture and digest index.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_buf       <= '0;
            r_digest    <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_err_set;
            r_out_valid <= (w_next_state == c_SEND);

            if ((r_state == c_LOAD) && w_in_fire) begin
                r_buf[r_cnt] <= in_data;
                if (in_last || (r_cnt == c_CNT_LAST)) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end else if ((r_state == c_DRAIN) && w_in_fire && in_last) begin
                r_cnt <= '0;
            end

            if ((r_state == c_WAIT) && sha_ready) begin
                r_digest <= sha_hash;
                r_idx    <= '0;
            end else if ((r_state == c_SEND) && w_out_fire) begin
                r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha_stream_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sha_stream_ctrl
// Description : Self-checking bench for sha_stream_ctrl with a behavioural
//               stand-in for the sha core (returns a chosen digest after a
//               random delay and raises stray Ready pulses while idle).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha_stream_ctrl;

    localparam int NL   = 3;
    localparam int NK   = 256;
    localparam int c_NB = NK / 8;
    localparam logic [NK-1:0] c_ABC_HASH =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic               clk       = 1'b0;
    logic               rst       = 1'b0;
    logic               in_valid  = 1'b0;
    logic [7:0]         in_data   = 8'h00;
    logic               in_last   = 1'b0;
    logic               out_ready = 1'b0;
    logic               sha_ready = 1'b0;
    logic [NK-1:0]      sha_hash  = '0;
    logic               in_ready;
    logic [NL-1:0][7:0] sha_data;
    logic               sha_enable;
    logic               out_valid;
    logic [7:0]         out_data;
    logic               out_last;
    logic               busy;
    logic               frame_err;

    int n_vec = 0;
    int n_err = 0;
    int n_enable = 0;
    int n_ferr = 0;

    logic [NK-1:0]      core_hash = '0;
    logic [NL-1:0][7:0] core_seen = '0;
    int                 core_delay = 0;
    bit                 core_pending = 1'b0;

    longint        t_last_hs = 0;
    longint        t_first_acc = 0;
    int            send_stalls = 0;
    byte unsigned  got_q[$];
    bit            got_last_q[$];
    int            hold_viol = 0;
    bit            coll_timeout = 1'b0;

    sha_stream_ctrl #(.NL(NL), .NK(NK)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .sha_data   (sha_data),
        .sha_enable (sha_enable),
        .sha_hash   (sha_hash),
        .sha_ready  (sha_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [NK-1:0] rand_hash();
        logic [NK-1:0] h;
        for (int w = 0; w < NK / 32; w++) h[w*32 +: 32] = $urandom();
        return h;
    endfunction

    // Core stand-in: snapshot Data on Enable, answer with core_hash later.
    always @(negedge clk) begin
        if (frame_err === 1'b1) n_ferr++;
        if (sha_enable === 1'b1) begin
            n_enable++;
            core_seen    = sha_data;
            core_pending = 1'b1;
            core_delay   = $urandom_range(1, 4);
            sha_ready    = 1'b0;
            sha_hash     = rand_hash();
        end else if (core_pending) begin
            core_delay = core_delay - 1;
            if (core_delay == 0) begin
                sha_ready    = 1'b1;
                sha_hash     = core_hash;
                core_pending = 1'b0;
            end else begin
                sha_ready = 1'b0;
                sha_hash  = rand_hash();
            end
        end else begin
            sha_ready = ($urandom_range(0, 3) == 0);
            sha_hash  = rand_hash();
        end
    end

    // Offer each byte until accepted; in_last rides on the final byte.
    task automatic send_frame(input byte unsigned b[$]);
        int n;
        send_stalls = 0;
        for (int i = 0; i < b.size(); i++) begin
            in_valid = 1'b1;
            in_data  = b[i];
            in_last  = (i == b.size() - 1);
            n = 0;
            while (n < 300) begin
                if (in_ready === 1'b1) begin
                    @(posedge clk); #1;
                    if (i == 0) t_first_acc = longint'($time) - 1;
                    break;
                end
                @(posedge clk); #1;
                n++;
                send_stalls++;
            end
            if (n >= 300) begin
                n_vec++; n_err++;
                $display("FAIL in_accept_timeout: byte %0d not accepted, in_ready=%b want 1", i, in_ready);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Gather nbytes digest bytes; bp toggles out_ready randomly.
    task automatic collect(input bit bp, input int nbytes);
        int         cyc = 0;
        bit         stalled = 1'b0;
        bit         took;
        logic [7:0] hd = 8'h00;
        logic       hl = 1'b0;
        got_q.delete();
        got_last_q.delete();
        hold_viol    = 0;
        coll_timeout = 1'b0;
        while (got_q.size() < nbytes && cyc < 500) begin
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            took = 1'b0;
            if (stalled && (out_valid !== 1'b1 || out_data !== hd || out_last !== hl)) hold_viol++;
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    got_q.push_back(out_data);
                    got_last_q.push_back(out_last);
                    took    = 1'b1;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    hd      = out_data;
                    hl      = out_last;
                end
            end else begin
                stalled = 1'b0;
            end
            @(posedge clk); #1;
            if (took) t_last_hs = longint'($time) - 1;
            cyc++;
        end
        out_ready = 1'b0;
        if (got_q.size() < nbytes) coll_timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (sha_enable !== 1'b0) begin n_err++; $display("FAIL rst_sha_enable: got %b want 0", sha_enable); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_last !== 1'b0) begin n_err++; $display("FAIL rst_out_last: got %b want 0", out_last); end
        n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_out_data: got %h want 00", out_data); end
        n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL rst_frame_err: got %b want 0", frame_err); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_vec++; if (sha_data !== '0) begin n_err++; $display("FAIL rst_sha_data: got %h want 0", sha_data); end
        rst = 1'b1;
    endtask

    task automatic test_abc(input bit bp);
        byte unsigned q[$];
        int           e0;
        logic [7:0]   want;
        q = '{8'h61, 8'h62, 8'h63};
        core_hash = c_ABC_HASH;
        e0 = n_enable;
        send_frame(q);
        n_vec++; if (sha_enable !== 1'b1) begin n_err++; $display("FAIL abc_enable_latency: got %b want 1", sha_enable); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL abc_in_ready_start: got %b want 0", in_ready); end
        collect(bp, c_NB);
        n_vec++; if (coll_timeout) begin n_err++; $display("FAIL abc_collect: got %0d bytes want %0d", got_q.size(), c_NB); end
        for (int k = 0; k < got_q.size(); k++) begin
            want = 8'(c_ABC_HASH >> (NK - 8 - 8 * k));
            n_vec++; if (got_q[k] !== want) begin n_err++; $display("FAIL abc_byte[%0d]: got %h want %h", k, got_q[k], want); end
            n_vec++; if (got_last_q[k] !== (k == c_NB - 1)) begin n_err++; $display("FAIL abc_last[%0d]: got %b want %b", k, got_last_q[k], (k == c_NB - 1)); end
        end
        n_vec++; if (hold_viol !== 0) begin n_err++; $display("FAIL abc_hold: got %0d violations want 0", hold_viol); end
        n_vec++; if (core_seen !== {8'h63, 8'h62, 8'h61}) begin n_err++; $display("FAIL abc_sha_data: got %h want 636261", core_seen); end
        n_vec++; if (n_enable - e0 !== 1) begin n_err++; $display("FAIL abc_enable_count: got %0d want 1", n_enable - e0); end
        n_vec++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL abc_idle_after: busy=%b in_ready=%b out_valid=%b want 0 1 0", busy, in_ready, out_valid);
        end
    endtask

    task automatic test_short_frame();
        byte unsigned q[$];
        int           e0, f0;
        q  = '{8'h61, 8'h62};
        e0 = n_enable;
        f0 = n_ferr;
        send_frame(q);
        n_vec++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL short_ferr_pulse: got %b want 1", frame_err); end
        n_vec++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL short_state: in_ready=%b busy=%b want 1 0", in_ready, busy); end
        repeat (4) @(posedge clk);
        #1;
        n_vec++; if (n_ferr - f0 !== 1) begin n_err++; $display("FAIL short_ferr_count: got %0d want 1", n_ferr - f0); end
        n_vec++; if (n_enable - e0 !== 0) begin n_err++; $display("FAIL short_no_enable: got %0d want 0", n_enable - e0); end
        n_vec++; if (send_stalls !== 0) begin n_err++; $display("FAIL short_stalls: got %0d want 0", send_stalls); end
        test_abc(1'b0);
    endtask

    task automatic test_long_frame();
        byte unsigned q[$];
        int           e0, f0;
        for (int i = 0; i < 5; i++) q.push_back(8'($urandom()));
        e0 = n_enable;
        f0 = n_ferr;
        send_frame(q);
        n_vec++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL long_ferr_pulse: got %b want 1", frame_err); end
        n_vec++; if (send_stalls !== 0) begin n_err++; $display("FAIL long_stalls: got %0d want 0", send_stalls); end
        repeat (4) @(posedge clk);
        #1;
        n_vec++; if (n_ferr - f0 !== 1) begin n_err++; $display("FAIL long_ferr_count: got %0d want 1", n_ferr - f0); end
        n_vec++; if (n_enable - e0 !== 0) begin n_err++; $display("FAIL long_no_enable: got %0d want 0", n_enable - e0); end
        n_vec++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL long_idle: busy=%b in_ready=%b want 0 1", busy, in_ready); end
    endtask

    task automatic test_random_frames();
        byte unsigned       q[$];
        logic [NL-1:0][7:0] m;
        logic [7:0]         want;
        for (int f = 0; f < 4; f++) begin
            q.delete();
            for (int i = 0; i < NL; i++) begin
                q.push_back(8'($urandom()));
                m[i] = q[i];
            end
            core_hash = rand_hash();
            send_frame(q);
            collect(1'(f % 2), c_NB);
            n_vec++; if (coll_timeout) begin n_err++; $display("FAIL rand_collect[%0d]: got %0d bytes want %0d", f, got_q.size(), c_NB); end
            n_vec++; if (core_seen !== m) begin n_err++; $display("FAIL rand_sha_data[%0d]: got %h want %h", f, core_seen, m); end
            n_vec++; if (hold_viol !== 0) begin n_err++; $display("FAIL rand_hold[%0d]: got %0d want 0", f, hold_viol); end
            for (int k = 0; k < got_q.size(); k++) begin
                want = 8'(core_hash >> (NK - 8 - 8 * k));
                n_vec++; if (got_q[k] !== want || got_last_q[k] !== (k == c_NB - 1)) begin
                    n_err++; $display("FAIL rand_byte[%0d][%0d]: got %h/%b want %h/%b", f, k, got_q[k], got_last_q[k], want, (k == c_NB - 1));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        byte unsigned q[$];
        int           e0;
        logic [7:0]   want;
        bit           ok1;
        q = '{8'h61, 8'h62, 8'h63};
        core_hash = c_ABC_HASH;
        e0 = n_enable;
        send_frame(q);
        fork
            send_frame(q);
            collect(1'b0, c_NB);
        join
        n_vec++; if (t_first_acc !== t_last_hs + 10) begin
            n_err++; $display("FAIL b2b_accept_time: got %0d want %0d", t_first_acc, t_last_hs + 10);
        end
        ok1 = !coll_timeout;
        for (int k = 0; k < got_q.size(); k++) begin
            want = 8'(c_ABC_HASH >> (NK - 8 - 8 * k));
            if (got_q[k] !== want) ok1 = 1'b0;
        end
        n_vec++; if (!ok1) begin n_err++; $display("FAIL b2b_digest1: got %0d bytes, first %h want %0d bytes matching", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00, c_NB); end
        collect(1'b1, c_NB);
        n_vec++; if (coll_timeout) begin n_err++; $display("FAIL b2b_collect2: got %0d bytes want %0d", got_q.size(), c_NB); end
        for (int k = 0; k < got_q.size(); k++) begin
            want = 8'(c_ABC_HASH >> (NK - 8 - 8 * k));
            n_vec++; if (got_q[k] !== want) begin n_err++; $display("FAIL b2b_digest2[%0d]: got %h want %h", k, got_q[k], want); end
        end
        n_vec++; if (n_enable - e0 !== 2) begin n_err++; $display("FAIL b2b_enable_count: got %0d want 2", n_enable - e0); end
    endtask

    task automatic test_reset_mid();
        byte unsigned q[$];
        logic [7:0]   want;
        q = '{8'h61, 8'h62, 8'h63};
        core_hash = c_ABC_HASH;
        send_frame(q);
        collect(1'b0, 10);
        want = 8'(c_ABC_HASH >> (NK - 8 - 80));
        n_vec++; if (out_valid !== 1'b1 || out_data !== want) begin
            n_err++; $display("FAIL mid_pre_reset: out_valid=%b out_data=%h want 1 %h", out_valid, out_data, want);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", busy); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
        n_vec++; if (out_last !== 1'b0 || out_data !== 8'h00) begin n_err++; $display("FAIL mid_out: last=%b data=%h want 0 00", out_last, out_data); end
        n_vec++; if (sha_data !== '0) begin n_err++; $display("FAIL mid_sha_data: got %h want 0", sha_data); end
        test_abc(1'b1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_abc(1'b0);
        test_abc(1'b1);
        test_short_frame();
        test_long_frame();
        test_random_frames();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sha_stream_ctrl.md
Name: sha_stream_ctrl

Overview:
- Host-side initiator for the sha top-level core.
- Collects a byte stream over a valid/ready interface into the core's fixed-length message buffer, then pulses the core's Enable and waits for its Ready.
- Captures the digest and returns it as a byte stream, most significant byte first.
- Sits between a host/DMA byte stream and one sha instance.

Parameters:
- NL, 64: message length in bytes; must equal the core's Nl.
- NK, 256: digest width in bits; must equal the core's Nk (160, 256 or 512).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  input byte valid
- in_data  in  8  input message byte
- in_last  in  1  marks final byte of a message frame
- in_ready  out  1  controller accepts input byte
- sha_data  out  8 x NL  byte array to core Data; element 0 = first received byte
- sha_enable  out  1  one-cycle start pulse to core Enable
- sha_hash  in  NK  core Hash
- sha_ready  in  1  core Ready
- out_valid  out  1  digest byte valid
- out_data  out  8  digest byte
- out_last  out  1  final digest byte
- out_ready  in  1  downstream accepts digest byte
- busy  out  1  high in every state except LOAD
- frame_err  out  1  one-cycle pulse when a malformed frame is dropped

Behaviour:
- States: LOAD, DRAIN, START, WAIT, SEND. Reset state is LOAD.
- Reset (rst==0 at a clk edge) takes effect from any state, mid-operation included. It clears the byte count, digest index, message buffer (all zero) and captured digest (zero).
- Output values after reset: sha_enable=0, out_valid=0, out_last=0, out_data=0, frame_err=0, busy=0, in_ready=1.
- Transfers occur only on clock edges where valid&&ready.
- LOAD:
  - in_ready=1.
  - Each accepted byte is written to buffer[cnt], then cnt increments.
  - Accepted in_last with cnt==NL-1: store the byte, go to START, cnt=0.
  - Accepted in_last with cnt<NL-1: frame_err=1 next cycle, cnt=0, stay in LOAD. Buffer contents do not matter.
  - Byte accepted at cnt==NL-1 without in_last: go to DRAIN.
- DRAIN:
  - in_ready=1; bytes are discarded.
  - On accepted in_last: frame_err pulse, cnt=0, go to LOAD.
- START:
  - sha_enable=1 for exactly this one cycle, then go to WAIT. in_ready=0.
- WAIT:
  - On sha_ready==1, register sha_hash into the digest register, idx=0, go to SEND.
  - sha_ready is ignored in every state other than WAIT.
  - No timeout.
- SEND:
  - out_valid=1.
  - out_data = digest[NK-1-8*idx -: 8].
  - out_last = (idx==NK/8-1).
  - out_data and out_last hold stable while out_ready=0.
  - On accept, idx increments. Accepting the last byte returns to LOAD, with in_ready=1 on the next cycle.
- The buffer is written only in LOAD, so sha_data is stable from START through SEND.
- out_valid is registered. The first digest byte appears one cycle after the capture edge.
- Latency: last input byte accepted at edge T → sha_enable high during cycle T+1.
- No input is accepted between START and the end of SEND. The next frame can start on the cycle after the last digest byte is accepted.
- Simultaneous in_valid during START/WAIT/SEND is not accepted (in_ready=0). out_ready outside SEND has no effect.

Test Plan:
- NL=3, NK=256, real core:
  - Send 'a','b','c' (0x61,0x62,0x63) with in_last on 0x63 → one sha_enable pulse.
  - After sha_ready, 32 bytes ba 78 16 bf … f2 00 15 ad emerge, out_last on byte 31 only; busy returns to 0 afterwards.
- Backpressure, same frame:
  - Toggle out_ready randomly with 50% duty → identical byte sequence.
  - out_data never changes while out_valid=1 and out_ready=0.
- Short frame, NL=3:
  - Send 0x61,0x62 with in_last on 0x62 → frame_err pulses once, no sha_enable, in_ready stays 1.
  - Following valid "abc" frame still yields ba78…15ad.
- Long frame, NL=3:
  - Send 5 bytes with in_last on the 5th → bytes 4–5 absorbed in DRAIN, one frame_err pulse, no sha_enable.
- Back-to-back frames:
  - Two "abc" frames, the second offered immediately → second accepted only after the first digest's out_last handshake; both digests correct.
- Reset mid-operation:
  - Assert rst=0 for one cycle during SEND at idx=10 → next cycle out_valid=0, busy=0, in_ready=1.
  - New frame hashes correctly with no stale bytes emitted.
